// File: rtl/instr_mem_responder_if.sv
// Load and fetch bus between the PC/loader side and the instruction memory.
// The master drives load and fetch requests; the slave returns fetch results.
interface instr_mem_responder_if #(
    parameter int W  = 6,
    parameter int IW = 32
);
    logic          ld_start;
    logic          ld_en;
    logic [IW-1:0] ld_data;
    logic          ld_done;
    logic          req;
    logic [W-1:0]  addr;
    logic          resp_valid;
    logic [IW-1:0] instr;
    logic          oob;
    logic          busy;
    logic          ld_ovf;
    logic          par_err;

    modport master (
        output ld_start, ld_en, ld_data, ld_done, req, addr,
        input  resp_valid, instr, oob, busy, ld_ovf, par_err
    );

    modport slave (
        input  ld_start, ld_en, ld_data, ld_done, req, addr,
        output resp_valid, instr, oob, busy, ld_ovf, par_err
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory with sequential load port and 1-cycle fetch responder.
// Optional INSTR_PARITY_EN stores an even-parity bit per entry and flags mismatches.
module instr_mem_responder #(
    parameter int            W   = 6,
    parameter int            IW  = 32,
    parameter logic [IW-1:0] NOP = '0
) (
    input  logic                  clk,
    input  logic                  clr,
    instr_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << W;

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        READY
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [IW-1:0] mem [DEPTH];
    logic [W-1:0]  wr_ptr;
    logic          full;
    logic [W:0]    prog_len;
    logic [W:0]    fill_cnt;
    logic          ld_ovf_q;
    logic          resp_valid_q;
    logic [IW-1:0] instr_q;
    logic          oob_q;

    logic          in_load;
    logic          in_ready;
    logic          wr_fire;
    logic          ovf_hit;
    logic          done_fire;
    logic          fetch_fire;
    logic          in_range;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // ld_start always restarts a load, even mid-load or alongside ld_done
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: begin
                if (bus.ld_start) state_nx = LOADING;
            end
            LOADING: begin
                if (bus.ld_start)     state_nx = LOADING;
                else if (bus.ld_done) state_nx = READY;
            end
            READY: begin
                if (bus.ld_start) state_nx = LOADING;
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_comb begin
        in_load    = (state == LOADING);
        in_ready   = (state == READY);
        bus.busy   = !in_ready;
        wr_fire    = in_load && bus.ld_en && !bus.ld_start && !full;
        ovf_hit    = in_load && bus.ld_en && !bus.ld_start && full;
        done_fire  = in_load && bus.ld_done && !bus.ld_start;
        fetch_fire = in_ready && bus.req;
    end

    assign in_range = {1'b0, bus.addr} < prog_len;
    assign fill_cnt = full ? (W+1)'(DEPTH) : {1'b0, wr_ptr};

    // Pointer saturates at the last entry; full marks the extra count
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr   <= '0;
            full     <= 1'b0;
            prog_len <= '0;
            ld_ovf_q <= 1'b0;
        end else begin
            if (bus.ld_start) begin
                wr_ptr <= '0;
                full   <= 1'b0;
            end else if (wr_fire) begin
                if (wr_ptr == W'(DEPTH - 1)) full <= 1'b1;
                else                         wr_ptr <= wr_ptr + 1'b1;
            end
            if (ovf_hit)   ld_ovf_q <= 1'b1;
            if (done_fire) prog_len <= fill_cnt + (W+1)'(wr_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= bus.ld_data;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            resp_valid_q <= 1'b0;
            instr_q      <= '0;
            oob_q        <= 1'b0;
        end else begin
            resp_valid_q <= fetch_fire;
            if (fetch_fire) begin
                instr_q <= in_range ? mem[bus.addr] : NOP;
                oob_q   <= !in_range;
            end
        end
    end

`ifdef INSTR_PARITY_EN
    logic mem_par [DEPTH];
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (wr_fire) mem_par[wr_ptr] <= ^bus.ld_data;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            par_err_q <= 1'b0;
        end else if (fetch_fire) begin
            par_err_q <= in_range &&
                         ((^mem[bus.addr]) != mem_par[bus.addr]);
        end
    end

    assign bus.par_err = par_err_q;
`else
    assign bus.par_err = 1'b0;
`endif

    assign bus.resp_valid = resp_valid_q;
    assign bus.instr      = instr_q;
    assign bus.oob        = oob_q;
    assign bus.ld_ovf     = ld_ovf_q;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: a queue-based program model
// predicts each fetch response; a negedge monitor pops and compares.
module tb_instr_mem_responder;
    localparam int W  = 6;
    localparam int IW = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    instr_mem_responder_if #(.W(W), .IW(IW)) bus ();

    instr_mem_responder #(.W(W), .IW(IW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic [IW-1:0] instr;
        logic          oob;
        logic          par_err;
    } resp_t;

    resp_t         exp_q[$];
    logic [IW-1:0] prog[$];
    logic [IW-1:0] committed[$];
    bit            loading;
    bit            ready;
    bit            ovf;
    bit            corrupt0;
    int            checks;
    int            errors;

    task automatic chk(string name, logic [IW-1:0] got, logic [IW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Program model: a word list being built, and the list committed by ld_done
    function automatic void model_edge();
        resp_t r;
        if (clr) begin
            loading = 0;
            ready   = 0;
            ovf     = 0;
            prog.delete();
            committed.delete();
            return;
        end
        if (bus.req && ready) begin
            if (int'(bus.addr) < committed.size()) begin
                r.instr   = committed[bus.addr];
                r.oob     = 1'b0;
                r.par_err = corrupt0 && (bus.addr == 0);
            end else begin
                r.instr   = '0;
                r.oob     = 1'b1;
                r.par_err = 1'b0;
            end
            exp_q.push_back(r);
        end
        if (bus.ld_start) begin
            loading = 1;
            ready   = 0;
            prog.delete();
        end else if (loading) begin
            if (bus.ld_en) begin
                if (prog.size() < DEPTH) prog.push_back(bus.ld_data);
                else                     ovf = 1;
            end
            if (bus.ld_done) begin
                committed = prog;
                corrupt0  = 0;
                loading   = 0;
                ready     = 1;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", 32'(bus.busy), 32'(!ready));
        chk("ld_ovf", 32'(bus.ld_ovf), 32'(ovf));
    endtask

    task automatic idle_inputs();
        bus.ld_start = 0;
        bus.ld_en    = 0;
        bus.ld_data  = '0;
        bus.ld_done  = 0;
        bus.req      = 0;
        bus.addr     = '0;
    endtask

    task automatic load_word(logic [IW-1:0] d);
        bus.ld_en   = 1;
        bus.ld_data = d;
        step();
        bus.ld_en   = 0;
    endtask

    task automatic pulse_start();
        bus.ld_start = 1;
        step();
        bus.ld_start = 0;
    endtask

    task automatic pulse_done();
        bus.ld_done = 1;
        step();
        bus.ld_done = 0;
    endtask

    task automatic fetch(logic [W-1:0] a);
        bus.req  = 1;
        bus.addr = a;
        step();
        bus.req  = 0;
    endtask

    always @(negedge clk) begin
        resp_t r;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("resp_valid", 32'(bus.resp_valid), 32'd1);
            if (bus.resp_valid === 1'b1) begin
                chk("instr", bus.instr, r.instr);
                chk("oob", 32'(bus.oob), 32'(r.oob));
                chk("par_err", 32'(bus.par_err), 32'(r.par_err));
            end
        end else if (bus.resp_valid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid=%b expected 0",
                     bus.resp_valid);
        end
    end

    initial begin
        clr = 1;
        idle_inputs();
        step();
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_oob", 32'(bus.oob), 32'd0);
        chk("rst_par_err", 32'(bus.par_err), 32'd0);
        clr = 0;

        // Fetch and stray load write while EMPTY are refused
        bus.ld_en   = 1;
        bus.ld_data = 32'h1111_1111;
        fetch(6'd3);
        bus.ld_en   = 0;

        pulse_start();
        load_word(32'h2008_0005);
        load_word(32'h2009_0007);
        load_word(32'h0109_5020);
        pulse_done();
        fetch(6'd1);

        fetch(6'd5);
        fetch(6'd0);
        fetch(6'd1);
        fetch(6'd2);
        fetch(6'd3);

        pulse_start();
        for (int i = 0; i < DEPTH; i++) load_word(IW'(i));
        load_word(32'hDEAD_BEEF);
        pulse_done();
        fetch(6'd63);
        fetch(6'd0);

        // Response issued on the same edge that leaves READY still arrives
        bus.req      = 1;
        bus.addr     = 6'd63;
        bus.ld_start = 1;
        step();
        idle_inputs();
        load_word(32'hAAAA_0001);
        load_word(32'hAAAA_0002);
        clr = 1;
        step();
        clr = 0;
        fetch(6'd0);
        pulse_start();
        bus.ld_en   = 1;
        bus.ld_done = 1;
        bus.ld_data = 32'h0000_1234;
        step();
        idle_inputs();
        fetch(6'd1);
        fetch(6'd0);

`ifdef INSTR_PARITY_EN
        dut.mem[0] = dut.mem[0] ^ 32'd1;
        committed[0] = committed[0] ^ 32'd1;
        corrupt0 = 1;
`endif
        fetch(6'd0);

        repeat (400) begin
            clr          = ($urandom_range(0, 63) == 0);
            bus.ld_start = ($urandom_range(0, 15) == 0);
            bus.ld_en    = !bus.ld_start && ($urandom_range(0, 1) == 1);
            bus.ld_done  = !bus.ld_start && ($urandom_range(0, 11) == 0);
            bus.ld_data  = $urandom;
            bus.req      = ($urandom_range(0, 1) == 1);
            bus.addr     = W'($urandom_range(0, 15));
            step();
        end
        clr = 0;
        idle_inputs();
        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
